// File: rtl/i_refill_responder.sv
// rtl/i_refill_responder.sv - I-cache refill responder: one-cycle ack, then back-to-back beats from sync-read imem
// Optional I_REFILL_OUT_REG_EN: registered data output with an extra PRE state ahead of ACK.
`ifndef CACHE_BLOCK_SIZE
`define CACHE_BLOCK_SIZE 64
`endif
`ifndef MEM_TRANS_SIZE
`define MEM_TRANS_SIZE 16
`endif

module i_refill_responder #(
  parameter int BLOCK_BITS = `CACHE_BLOCK_SIZE,
  parameter int TRANS_BITS = `MEM_TRANS_SIZE,
  parameter int ADDR_W     = 16 - $clog2(BLOCK_BITS),
  parameter int BEATS      = BLOCK_BITS / TRANS_BITS,
  parameter int MEM_ADDR_W = ADDR_W + $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  req,
  input  logic [ADDR_W-1:0]     address,
  output logic                  ack,
  output logic [TRANS_BITS-1:0] data,
  output logic                  mem_rd_en,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [TRANS_BITS-1:0] mem_rdata,
  output logic                  busy,
  output logic [15:0]           refill_count
);

  localparam int IDX_W = $clog2(BEATS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACK, S_STREAM, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] block_addr_q, block_addr_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [15:0]       refill_count_q, refill_count_d;
  logic              rd_beat;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= S_IDLE;
      block_addr_q   <= '0;
      beat_q         <= '0;
      out_q          <= '0;
      refill_count_q <= '0;
    end else begin
      state_q        <= state_d;
      block_addr_q   <= block_addr_d;
      beat_q         <= beat_d;
      out_q          <= out_d;
      refill_count_q <= refill_count_d;
    end
  end

  // beat_q is the next word to read; out_q counts beats already presented in STREAM.
  always_comb begin
    state_d        = state_q;
    block_addr_d   = block_addr_q;
    beat_d         = beat_q;
    out_d          = out_q;
    refill_count_d = refill_count_q;
    ack            = 1'b0;
    mem_rd_en      = 1'b0;
    mem_addr       = '0;
    rd_beat        = 1'b0;
    busy           = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (req) begin
          block_addr_d = address;
          beat_d       = '0;
          out_d        = '0;
`ifdef I_REFILL_OUT_REG_EN
          state_d      = S_PRE;
`else
          state_d      = S_ACK;
`endif
        end
      end
      S_PRE: begin
        rd_beat = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: begin
        ack     = 1'b1;
        rd_beat = (beat_q < BEATS_C);
        out_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        rd_beat = (beat_q < BEATS_C);
        if (out_q == LAST_C) begin
          refill_count_d = (refill_count_q == 16'hFFFF) ? refill_count_q : refill_count_q + 16'd1;
          state_d        = S_DONE;
        end else begin
          out_d = out_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rd_beat) begin
      mem_rd_en = 1'b1;
      mem_addr  = (MEM_ADDR_W'(block_addr_q) << IDX_W) | MEM_ADDR_W'(beat_q);
      beat_d    = beat_q + CNT_W'(1);
    end
  end

`ifdef I_REFILL_OUT_REG_EN
  logic [TRANS_BITS-1:0] data_q, data_d;

  // Load only when the next cycle presents a beat, so the register reads 0 outside STREAM.
  always_comb begin
    data_d = (state_d == S_STREAM) ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data = data_q;
`else
  assign data = (state_q == S_STREAM) ? mem_rdata : '0;
`endif

  assign refill_count = refill_count_q;

endmodule

// File: tb/tb_i_refill_responder.sv
// tb/tb_i_refill_responder.sv - table-driven and randomized bench for i_refill_responder against a timing-rule model
module tb_i_refill_responder;

  localparam int ADDR_W = 10;
  localparam int TW     = 16;
  localparam int BEATS  = 4;
  localparam int MAW    = 12;
`ifdef I_REFILL_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic              clk = 1'b0;
  logic              n_rst;
  logic              req;
  logic [ADDR_W-1:0] address;
  logic              ack;
  logic [TW-1:0]     data;
  logic              mem_rd_en;
  logic [MAW-1:0]    mem_addr;
  logic [TW-1:0]     mem_rdata;
  logic              busy;
  logic [15:0]       refill_count;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_count;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       base;
    int                hold;
    bit                early;
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  i_refill_responder dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .req          (req),
    .address      (address),
    .ack          (ack),
    .data         (data),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .refill_count (refill_count)
  );

  logic [TW-1:0] mem [0:(1<<MAW)-1];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle c counts edges after req is raised: read j issues at c=1+j, ack at c=1+LAT, beat k at c=2+LAT+k.
  task automatic refill(input logic [ADDR_W-1:0] a, input logic [15:0] base, input int hold, input bit early);
    address = a;
    req     = 1'b1;
    for (int c = 1; c <= 1 + LAT + BEATS; c++) begin
      step();
      chk($sformatf("ack a=%0h c=%0d", a, c), 32'(ack), 32'(c == 1 + LAT));
      chk($sformatf("data a=%0h c=%0d", a, c), 32'(data),
          (c >= 2 + LAT) ? 32'(16'(32'(base) + 32'(c - 2 - LAT))) : 32'd0);
      chk($sformatf("rd_en a=%0h c=%0d", a, c), 32'(mem_rd_en), 32'(c <= BEATS));
      if (c <= BEATS)
        chk($sformatf("mem_addr a=%0h c=%0d", a, c), 32'(mem_addr), (32'(a) * BEATS + 32'(c - 1)) % 4096);
      chk($sformatf("busy a=%0h c=%0d", a, c), 32'(busy), 32'd1);
      if (early && c == 2) address = 10'h001;
      if (early && c == 3) req = 1'b0;
    end
    if (model_count != 16'hFFFF) model_count++;
    step();
    chk($sformatf("done data a=%0h", a), 32'(data), 32'd0);
    chk($sformatf("done ack a=%0h", a), 32'(ack), 32'd0);
    chk($sformatf("done busy a=%0h", a), 32'(busy), 32'd1);
    chk($sformatf("count a=%0h", a), 32'(refill_count), 32'(model_count));
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        step();
        chk($sformatf("hold ack h=%0d", h), 32'(ack), 32'd0);
        chk($sformatf("hold busy h=%0d", h), 32'(busy), 32'd1);
        chk($sformatf("hold data h=%0d", h), 32'(data), 32'd0);
      end
    end
    req = 1'b0;
    step();
    chk($sformatf("idle busy a=%0h", a), 32'(busy), 32'd0);
    chk($sformatf("idle rd_en a=%0h", a), 32'(mem_rd_en), 32'd0);
  endtask

  initial begin
    for (int w = 0; w < (1 << MAW); w++) mem[w] = 16'(32'hA000 + w);
    tbl[0] = '{addr: 10'h005, base: 16'hA014, hold: 10, early: 1'b0};
    tbl[1] = '{addr: 10'h3FF, base: 16'hAFFC, hold: 0,  early: 1'b0};
    tbl[2] = '{addr: 10'h005, base: 16'hA014, hold: 0,  early: 1'b1};
    tbl[3] = '{addr: 10'h123, base: 16'hA48C, hold: 2,  early: 1'b0};
    tbl[4] = '{addr: 10'h000, base: 16'hA000, hold: 1,  early: 1'b0};

    n_rst = 1'b0;
    req = 1'b0;
    address = '0;
    model_count = 16'd0;
    step();
    step();
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst data", 32'(data), 32'd0);
    chk("rst rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst count", 32'(refill_count), 32'd0);
    n_rst = 1'b1;
    step();

    for (int i = 0; i < 5; i++) refill(tbl[i].addr, tbl[i].base, tbl[i].hold, tbl[i].early);

    // Abort mid-transfer with an asynchronous reset between edges.
    address = 10'h005;
    req = 1'b1;
    step();
    step();
    step();
    n_rst = 1'b0;
    #1;
    model_count = 16'd0;
    chk("midrst ack", 32'(ack), 32'd0);
    chk("midrst data", 32'(data), 32'd0);
    chk("midrst rd_en", 32'(mem_rd_en), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst count", 32'(refill_count), 32'd0);
    req = 1'b0;
    step();
    chk("midrst hold data", 32'(data), 32'd0);
    n_rst = 1'b1;
    step();
    refill(10'h005, 16'hA014, 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      refill(a, 16'(32'hA000 + 32'(a) * BEATS), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    force dut.refill_count_q = 16'hFFFE;
    step();
    release dut.refill_count_q;
    model_count = 16'hFFFE;
    chk("sat preset", 32'(refill_count), 32'hFFFE);
    refill(10'h2A0, 16'hAA80, 0, 1'b0);
    refill(10'h001, 16'hA004, 0, 1'b0);
    chk("sat hold", 32'(refill_count), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i_refill_responder.md
Name: i_refill_responder

Overview:
- Memory-side end of the instruction-cache refill interface. Accepts a block-address refill request from the I-cache, returns a one-cycle ack, then streams the block as back-to-back MEM_TRANS_SIZE-wide beats, lowest beat first.
- Sits between the I-cache and the synchronous-read instruction memory. Keeps a saturating refill counter for performance monitoring.

Parameters:
- BLOCK_BITS, default `CACHE_BLOCK_SIZE (64): cache line size in bits.
- TRANS_BITS, default `MEM_TRANS_SIZE (16): beat width in bits. BLOCK_BITS must be an integer multiple of TRANS_BITS.
- ADDR_W, default 16 - $clog2(BLOCK_BITS): block address width.
- BEATS, derived: BLOCK_BITS / TRANS_BITS.
- MEM_ADDR_W, derived: ADDR_W + $clog2(BEATS).

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous active-low reset.
- req  in  1  refill request from the cache (level).
- address  in  ADDR_W  block address; sampled when the request is accepted.
- ack  out  1  one-cycle acknowledge.
- data  out  TRANS_BITS  beat data.
- mem_rd_en  out  1  instruction memory read strobe.
- mem_addr  out  MEM_ADDR_W  word address, computed as {block_addr, beat}.
- mem_rdata  in  TRANS_BITS  memory read data, valid exactly 1 cycle after mem_rd_en.
- busy  out  1  high in any state except IDLE.
- refill_count  out  16  number of completed refills, saturating.

Behaviour:
- Reset is asynchronous on n_rst low, with all of the following values:
  - state = IDLE
  - ack = 0, data = 0, mem_rd_en = 0, mem_addr = 0
  - beat counter = 0, refill_count = 0
  - busy = 0
- Reset asserted mid-transfer aborts the transfer immediately; no further beats are sent.
- IDLE:
  - When req = 1, latch address into block_addr, clear beat = 0, go to ACK.
  - When req = 0, stay in IDLE.
- ACK (1 cycle):
  - Drive ack = 1.
  - Drive mem_rd_en = 1 with mem_addr = {block_addr, 0}.
  - Set beat = 1, go to STREAM.
- STREAM (BEATS cycles):
  - data = mem_rdata, i.e. the beat read in the previous cycle.
  - While beat < BEATS, drive mem_rd_en = 1 with mem_addr = {block_addr, beat}, then increment beat.
  - On the cycle that presents beat BEATS-1: drive mem_rd_en = 0, increment refill_count (saturates at 0xFFFF), go to DONE.
- DONE:
  - data = 0, ack = 0.
  - Stay in DONE while req = 1; go to IDLE when req = 0.
  - Each req assertion therefore yields exactly one refill. req must be low for at least 1 cycle between refills.
- Outside STREAM, data is 0.
- Latency from req sampled in IDLE (cycle T):
  - ack at T+1.
  - Beat k at T+2+k, for k = 0..BEATS-1.
  - Matches a cache that begins counting beats the cycle after ack.
- req dropping during ACK or STREAM does not abort; the full block is always delivered.
- Changes on address after acceptance are ignored.
- Beat index width is $clog2(BEATS).
- When BEATS = 1: STREAM lasts 1 cycle and mem_rd_en is asserted only in ACK.

Optional Feature:
- Macro: I_REFILL_OUT_REG_EN.
- When defined:
  - data is driven from a register loaded from mem_rdata, removing the combinational memory-to-cache path.
  - A PRE state is inserted between IDLE and ACK. PRE issues the read for beat 0. ACK then issues beat 1, and so on.
  - ack moves to T+2 and beat k to T+3+k. Beat spacing remains back-to-back.
  - The data register is reset to 0 and cleared outside STREAM.
- When undefined: behaviour is exactly as described above, with no PRE state.

Test Plan:
- Basic refill (defaults, BEATS = 4; mem word w preloaded with 0xA000+w). address = 0x005, req held high:
  - ack at T+1.
  - mem_addr sequence 0x014, 0x015, 0x016, 0x017.
  - data 0xA014, 0xA015, 0xA016, 0xA017 at T+2..T+5.
  - refill_count = 1.
- Hold in DONE: req kept high 10 cycles after the last beat -> no second ack. Then req low 1 cycle and high with address 0x3FF -> second refill returns 0xA000+0xFFC..0xFFF (16-bit wrap), and refill_count = 2.
- Address change and early release: address changed to 0x001 at T+2 and req dropped at T+3 of a 0x005 refill -> all 4 beats still come from words 0x014..0x017.
- Reset mid-transfer: n_rst pulsed low at T+3 -> ack, data and mem_rd_en go to 0 immediately, busy = 0, refill_count = 0, and the next req restarts cleanly with ack.
- Counter saturation: force 65537 refills -> refill_count holds at 0xFFFF.
- Registered output: with I_REFILL_OUT_REG_EN defined, address 0x005 -> ack at T+2, data 0xA014..0xA017 at T+3..T+6, and data = 0 outside STREAM.
